// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request channel, small instruction buffer to decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / flush_count performance counters.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [6:0]      id_opcode,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
`else
  output logic [6:0]      id_opcode
`endif
);

  localparam int             PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, req_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [31:0]       buf_instr_q [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc_q    [BUF_DEPTH];

  logic            req_fire, push, pop;
  logic [XLEN-1:0] redirect_target;

  // Only one request is ever in flight, so in ISSUE a free slot is also the slot
  // reserved for the response; the buffer can therefore never overflow.
  assign imem_req_valid  = !rst && (state_q == ISSUE) && (count_q < DEPTH_C);
  assign imem_req_addr   = pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // A redirect cancels both buffer operations of its cycle.
  assign push = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  assign id_valid  = (count_q != '0);
  assign id_instr  = buf_instr_q[rd_ptr_q];
  assign id_pc     = buf_pc_q[rd_ptr_q];
  assign id_opcode = id_instr[6:0];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISSUE:   if (req_fire) state_d = redirect_valid ? DISCARD : WAIT;
      // A response landing in the redirect cycle is the in-flight one; it is
      // dropped there and nothing is left to discard.
      WAIT: begin
        if (imem_resp_valid)     state_d = ISSUE;
        else if (redirect_valid) state_d = DISCARD;
      end
      DISCARD: if (imem_resp_valid) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ISSUE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (req_fire) req_pc_q <= pc_q;
      if (redirect_valid) pc_q <= redirect_target;
      else if (req_fire)  pc_q <= pc_q + XLEN'(4);
    end
  end

  // NOTE: the buffer storage is reset on purpose: its head drives id_instr/id_pc,
  // which must show a NOP at PC 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= NOP;
        buf_pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_instr_q[wr_ptr_q] <= imem_resp_data;
        buf_pc_q[wr_ptr_q]    <= req_pc_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (pop)            fetch_count <= fetch_count + 32'd1;
      if (redirect_valid) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized imem/decode/redirect stimulus with a
// sequential-PC reference queue checked by an independent monitor process.
module tb_fetch_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_PERF_CNT_EN
    .id_opcode(id_opcode), .fetch_count(fetch_count), .flush_count(flush_count)
`else
    .id_opcode(id_opcode)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: word at address 0 is addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Knobs set by the directed sequence at posedge, applied by the driver at negedge.
  bit          k_rst = 1'b1;
  int          k_ready_mode = 1;   // 0: id_ready low, 1: high, 2: random
  bit          k_req_rand = 1'b0;
  int          k_lat_min = 1, k_lat_max = 1;
  int          k_trig = 0;         // 1 redirect now, 2 redirect in WAIT, 3 redirect on resp+pop, 4 reset in WAIT
  bit          k_rand_redirect = 1'b0;
  logic [31:0] k_target = 32'h0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] acc_log[$];         // accepted request addresses since last redirect/reset
  logic [31:0] exp_q[$];           // reference: PCs decode must see, in order
  int          cyc = 0;
  int          pops = 0;
  int          pops_since_rst = 0;
  int          flush_since_rst = 0;

  // After a redirect or reset the architected stream is simply target, target+4, ...
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Driver: memory model, decode ready, redirect and reset injection.
  always @(negedge clk) begin : drv
    logic do_redir, do_rst;
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = k_req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    case (k_ready_mode)
      0:       id_ready = 1'b0;
      1:       id_ready = 1'b1;
      default: id_ready = 1'($urandom_range(0, 1));
    endcase
    do_redir = 1'b0;
    do_rst   = k_rst;
    case (k_trig)
      1: do_redir = 1'b1;
      2: do_redir = (pend_q.size() > 0) && !imem_resp_valid;
      3: if (imem_resp_valid && id_valid) begin do_redir = 1'b1; id_ready = 1'b1; end
      4: do_rst = (pend_q.size() > 0) && !imem_resp_valid;
      default: ;
    endcase
    if (k_trig != 0 && (do_redir || do_rst)) k_trig = 0;
    if (k_rand_redirect && $urandom_range(0, 29) == 0) begin
      do_redir = 1'b1;
      k_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    redirect_valid = do_redir;
    redirect_pc    = k_target;
    rst            = do_rst;
    if (do_rst) begin
      refill(RESET_PC);
      acc_log.delete();
      pops_since_rst  = 0;
      flush_since_rst = 0;
    end else if (do_redir) begin
      refill(k_target & ~32'h3);
      acc_log.delete();
      flush_since_rst++;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(k_lat_min, k_lat_max)});
      if (!do_redir && !do_rst) acc_log.push_back(imem_req_addr);
    end
  end

  // Monitor: compares every decode handshake with the reference queue and checks head stability.
  always @(negedge clk) begin : mon
    logic        prev_stall;
    logic [31:0] prev_pc, prev_instr, exp_pc, exp_instr;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("head_hold_valid", id_valid, 1'b1);
        check("head_hold_pc", id_pc, prev_pc);
        check("head_hold_instr", id_instr, prev_instr);
      end
      if (id_valid && id_ready && !redirect_valid) begin
        exp_pc = exp_q.pop_front();
        exp_q.push_back(exp_q[$] + 32'd4);
        exp_instr = mem_word(exp_pc);
        check("id_pc", id_pc, exp_pc);
        check("id_instr", id_instr, exp_instr);
        check("id_opcode", id_opcode, exp_instr[6:0]);
        pops++;
        pops_since_rst++;
      end
      prev_stall = id_valid && !id_ready && !redirect_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 400 && pops < n; i++) @(posedge clk);
    check(name, pops >= n, 1'b1);
  endtask

  task automatic wait_trig(input string name);
    for (int i = 0; i < 200 && k_trig != 0; i++) @(posedge clk);
    check(name, k_trig == 0, 1'b1);
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int i = 0; i < 200 && acc_log.size() < n; i++) @(posedge clk);
    check(name, acc_log.size() >= n, 1'b1);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);
    @(posedge clk) k_rst = 1'b0;

    // 1: sequential fetch from RESET_PC, 1-cycle memory.
    @(negedge clk); #3;
    check("t1_first_req_valid", imem_req_valid, 1'b1);
    check("t1_first_req_addr", imem_req_addr, 32'h0);
    wait_pops(3, "t1_progress");

    // 2: decode stall fills the buffer and stops requests; release drains in order.
    @(posedge clk) k_ready_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); #3;
    check("t2_full_no_req", imem_req_valid, 1'b0);
    check("t2_full_valid", id_valid, 1'b1);
    @(posedge clk) k_ready_mode = 1;
    wait_pops(pops + 4, "t2_drain");

    // 3: redirect while waiting on a slow response.
    @(posedge clk) begin k_lat_min = 3; k_lat_max = 3; k_target = 32'h100; k_trig = 2; end
    wait_trig("t3_trigger");
    @(negedge clk); #3;
    check("t3_flushed", id_valid, 1'b0);
    wait_acc(1, "t3_req_after");
    check("t3_req_addr", acc_log[0], 32'h100);
    wait_pops(pops + 2, "t3_progress");

    // 4: redirect coincident with a pop and a push.
    @(posedge clk) begin k_lat_min = 2; k_lat_max = 2; k_ready_mode = 0; k_target = 32'h100; k_trig = 3; end
    wait_trig("t4_trigger");
    @(negedge clk); #3;
    check("t4_empty", id_valid, 1'b0);
    wait_acc(1, "t4_req_after");
    check("t4_req_addr", acc_log[0], 32'h100);
    @(posedge clk) k_ready_mode = 1;
    wait_pops(pops + 2, "t4_progress");

    // 5: PC wraps past the top of the address space.
    @(posedge clk) begin k_lat_min = 1; k_lat_max = 1; k_target = 32'hFFFF_FFFC; k_trig = 1; end
    wait_trig("t5_trigger");
    wait_acc(2, "t5_req_after");
    check("t5_req_top", acc_log[0], 32'hFFFF_FFFC);
    check("t5_req_wrap", acc_log[1], 32'h0);
    wait_pops(pops + 2, "t5_progress");

    // 6: reset while waiting; the late response must be ignored.
    @(posedge clk) begin k_lat_min = 2; k_lat_max = 2; k_trig = 4; end
    wait_trig("t6_trigger");
    @(negedge clk); #3;
    check("t6_after_rst_valid", id_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_fetch_count", fetch_count, 32'h0);
    check("t6_flush_count", flush_count, 32'h0);
`endif
    @(negedge clk); #3;
    check("t6_stale_ignored", id_valid, 1'b0);
    wait_acc(1, "t6_req_after");
    check("t6_req_addr", acc_log[0], RESET_PC);
    wait_pops(pops + 2, "t6_progress");

    // Randomized traffic: memory stalls, variable latency, decode backpressure, redirects.
    @(posedge clk) begin
      k_lat_min = 1; k_lat_max = 3; k_req_rand = 1'b1; k_ready_mode = 2; k_rand_redirect = 1'b1;
    end
    repeat (3000) @(posedge clk);
    @(posedge clk) begin k_rand_redirect = 1'b0; k_req_rand = 1'b0; k_ready_mode = 1; end
    wait_pops(pops + 20, "rand_tail_progress");

`ifdef FETCH_PERF_CNT_EN
    @(posedge clk) k_ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    check("perf_fetch_count", fetch_count, 32'(pops_since_rst));
    check("perf_flush_count", flush_count, 32'(flush_since_rst));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
